// File: rtl/aes_pkg.sv
// Shared AES types, the sparse MixColumns FSM encoding and column helpers.
package aes_pkg;

    typedef enum logic [1:0] {
        CIPH_FWD = 2'b01,
        CIPH_INV = 2'b10
    } ciph_op_e;

    // Pairwise Hamming distance 4 so a single upset never lands on another
    // legal state.
    localparam int McsStateWidth = 6;

    typedef enum logic [McsStateWidth-1:0] {
        MCS_IDLE  = 6'b011101,
        MCS_BUSY  = 6'b110000,
        MCS_DONE  = 6'b001010,
        MCS_ERROR = 6'b100111
    } mcs_state_e;

    typedef logic [3:0][7:0]       aes_col_t;
    typedef logic [3:0][3:0][7:0]  aes_state_t;

    // Column c of state[row][col] as {s[3][c], s[2][c], s[1][c], s[0][c]}
    function automatic aes_col_t aes_state_col_get(aes_state_t s, logic [1:0] c);
        aes_col_t col;
        for (int r = 0; r < 4; r++) begin
            col[r] = s[r][c];
        end
        return col;
    endfunction

    function automatic aes_state_t aes_state_col_set(aes_state_t s, logic [1:0] c,
                                                     aes_col_t col);
        aes_state_t res;
        res = s;
        for (int r = 0; r < 4; r++) begin
            res[r][c] = col[r];
        end
        return res;
    endfunction

    // GF(2^8) multiply by x, reduction polynomial x^8+x^4+x^3+x+1
    function automatic logic [7:0] aes_mul2(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] aes_mul4(logic [7:0] b);
        return aes_mul2(aes_mul2(b));
    endfunction

endpackage

// File: rtl/aes_mix_single_column.sv
// One-column MixColumns / InvMixColumns, purely combinational.
module aes_mix_single_column
    import aes_pkg::*;
(
    input  ciph_op_e        op_i,
    input  logic [3:0][7:0] data_i,
    output logic [3:0][7:0] data_o
);

    logic [7:0]      pre_u;
    logic [7:0]      pre_v;
    logic [3:0][7:0] pre;

    // Inverse = forward matrix applied after a cheap {05,00,04,00} pre-multiply,
    // so both directions share the forward xtime network.
    always_comb begin
        pre_u  = (op_i == CIPH_INV) ? aes_mul4(data_i[0] ^ data_i[2]) : 8'h00;
        pre_v  = (op_i == CIPH_INV) ? aes_mul4(data_i[1] ^ data_i[3]) : 8'h00;
        pre[0] = data_i[0] ^ pre_u;
        pre[1] = data_i[1] ^ pre_v;
        pre[2] = data_i[2] ^ pre_u;
        pre[3] = data_i[3] ^ pre_v;
    end

    // Forward circulant {02,03,01,01}: 2*a ^ 3*b ^ c ^ d = 2*(a^b) ^ b ^ c ^ d
    always_comb begin
        data_o[0] = aes_mul2(pre[0] ^ pre[1]) ^ pre[1] ^ pre[2] ^ pre[3];
        data_o[1] = aes_mul2(pre[1] ^ pre[2]) ^ pre[2] ^ pre[3] ^ pre[0];
        data_o[2] = aes_mul2(pre[2] ^ pre[3]) ^ pre[3] ^ pre[0] ^ pre[1];
        data_o[3] = aes_mul2(pre[3] ^ pre[0]) ^ pre[0] ^ pre[1] ^ pre[2];
    end

endmodule

// File: rtl/aes_mix_columns_serial.sv
// Iterative MixColumns: ColsPerCycle columns per cycle over a registered state.
module aes_mix_columns_serial
    import aes_pkg::*;
#(
    parameter int ColsPerCycle = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  ciph_op_e             op_i,
    input  logic [3:0][3:0][7:0] state_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [3:0][3:0][7:0] state_o,
    output logic                 err_o
);

    localparam int NumBusyCycles = 4 / ColsPerCycle;
    localparam int CntW          = (NumBusyCycles > 1) ? $clog2(NumBusyCycles) : 1;

    if (!(ColsPerCycle == 1 || ColsPerCycle == 2 || ColsPerCycle == 4)) begin : gen_bad_cols
        $error("aes_mix_columns_serial: ColsPerCycle must be 1, 2 or 4");
    end

    mcs_state_e                        fsm_q;
    aes_state_t                        state_q;
    aes_state_t                        state_busy;
    ciph_op_e                          op_q;
    logic [CntW-1:0]                   cnt_q;
    logic                              in_ready_q;
    logic                              out_valid_q;
    logic                              err_q;

    logic [ColsPerCycle-1:0][1:0]      col_idx;
    logic [ColsPerCycle-1:0][3:0][7:0] mc_in;
    logic [ColsPerCycle-1:0][3:0][7:0] mc_out;

    for (genvar i = 0; i < ColsPerCycle; i++) begin : gen_col
        assign col_idx[i] = 2'(32'(cnt_q) * ColsPerCycle + i);
        assign mc_in[i]   = aes_state_col_get(state_q, col_idx[i]);

        aes_mix_single_column u_mix (
            .op_i   (op_q),
            .data_i (mc_in[i]),
            .data_o (mc_out[i])
        );
    end

    // Write the processed slice back into its own columns
    always_comb begin
        state_busy = state_q;
        for (int i = 0; i < ColsPerCycle; i++) begin
            state_busy = aes_state_col_set(state_busy, col_idx[i], mc_out[i]);
        end
    end

    // Control FSM with registered handshake/error outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q       <= MCS_IDLE;
            state_q     <= '0;
            op_q        <= CIPH_FWD;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (fsm_q)
                MCS_IDLE: begin
                    if (clear_i) begin
                        state_q <= '0;
                        cnt_q   <= '0;
                    end else if (in_valid_i) begin
                        op_q       <= op_i;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        if (op_i == CIPH_FWD || op_i == CIPH_INV) begin
                            state_q <= state_i;
                            fsm_q   <= MCS_BUSY;
                        end else begin
                            state_q <= '0;
                            err_q   <= 1'b1;
                            fsm_q   <= MCS_ERROR;
                        end
                    end
                end
                MCS_BUSY: begin
                    if (clear_i) begin
                        state_q    <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b1;
                        fsm_q      <= MCS_IDLE;
                    end else begin
                        state_q <= state_busy;
                        if (cnt_q == CntW'(NumBusyCycles - 1)) begin
                            cnt_q       <= '0;
                            out_valid_q <= 1'b1;
                            fsm_q       <= MCS_DONE;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end
                MCS_DONE: begin
                    if (clear_i) begin
                        state_q     <= '0;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm_q       <= MCS_IDLE;
                    end else if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm_q       <= MCS_IDLE;
                    end
                end
                MCS_ERROR: begin
                    state_q     <= '0;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    err_q       <= 1'b1;
                end
                default: begin
                    state_q     <= '0;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    err_q       <= 1'b1;
                    fsm_q       <= MCS_ERROR;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign state_o     = state_q;
    assign err_o       = err_q;

endmodule
